// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and the bit-serial adder.
// master drives the request (start, a, b, cin), slave returns status and result.
// Ports: start/a/b/cin request side; busy/done/sum/cout completion side.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder controller: feeds a one-bit FullAdder LSB first, carry kept in a flop.
// Latency: start accepted on E0, bits on E1..E_WIDTH, done pulses the cycle after E_WIDTH.
// Backpressure: none; start is ignored while busy (ADD or DONE) and is never queued.
// Ports: clk, reset (sync, active-high); bus.slave carries start/a/b/cin in and
//        busy/done/sum/cout out. sum/cout hold from one completion to the next.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Bit 0 of the result register would be shifted out before it is ever read,
    // so only the upper WIDTH-1 partial-result bits are stored.
    logic [WIDTH-1:1] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_full;

    FullAdder u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Ci   (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Result register after this edge's bit is inserted at the top.
    assign res_full = {fa_sum, res_sh};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_full[WIDTH-1:1];
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    // Final bit: publish the full result straight from the adder so
                    // partial results never appear on sum.
                    if (cnt == LAST_BIT) begin
                        sum_q  <= res_full;
                        cout_q <= fa_cout;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // Unconditional return; a start seen here is dropped.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// One-bit full-adder cell driven by the serial adder.
// Latency: combinational.
// Backpressure: none.
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Ci;
    assign Cout = (A & B) | (Ci & (A ^ B));
endmodule
